// File: rtl/float_signinj_pipe.sv
// float_signinj_pipe: pipelined multi-lane FSGNJ/FSGNJN/FSGNJX unit with
// valid/ready handshakes on both sides, per-lane enables and detection of
// undefined opcodes.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake (in_ready = pipeline may advance)
//   float1               packed magnitude operands, lane i at [i*FW +: FW]
//   float2               packed sign-source operands, same packing
//   sgnj_type            operation shared by all lanes of a transaction
//   lane_en              per-lane enable, a disabled lane passes float1 through
//   out_valid / out_ready output handshake
//   out                  packed results, same packing as float1
//   invalid_op           opcode of the output transaction was undefined

package float_signinj_pipe_pkg;
   localparam int unsigned HALF_FLOAT_W = 16;

   typedef enum logic [1:0] {
      RM_J  = 2'b00,
      RM_JN = 2'b01,
      RM_JX = 2'b10
   } fpu_sgnj_type_t;
endpackage

module float_signinj_pipe
   import float_signinj_pipe_pkg::*;
#(
   parameter int unsigned LANES       = 4,
   parameter int unsigned FLOAT_WIDTH = HALF_FLOAT_W,
   parameter int unsigned PIPE_DEPTH  = 2
) (
   input  logic                         CLK,
   input  logic                         nRST,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [LANES*FLOAT_WIDTH-1:0] float1,
   input  logic [LANES*FLOAT_WIDTH-1:0] float2,
   input  fpu_sgnj_type_t               sgnj_type,
   input  logic [LANES-1:0]             lane_en,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [LANES*FLOAT_WIDTH-1:0] out,
   output logic                         invalid_op
);

   localparam int unsigned DW   = LANES * FLOAT_WIDTH;
   localparam int unsigned LAST = PIPE_DEPTH - 1;

   logic [LANES-1:0] s1_c;
   logic [LANES-1:0] s2_c;
   logic [LANES-1:0] sgn_c;
   logic [DW-1:0]    res_c;
   logic             inv_c;
   logic             advance_c;

   logic [PIPE_DEPTH-1:0] vld_q, vld_d;
   logic [PIPE_DEPTH-1:0] inv_q, inv_d;
   logic [DW-1:0]         data_q [PIPE_DEPTH];
   logic [DW-1:0]         data_d [PIPE_DEPTH];

   // Only the sign bits of float2 are consumed; fold the rest so they read as used.
   logic unused_float2_c;
   assign unused_float2_c = ^float2;

   // Extract per-lane sign bits.
   always_comb begin
      s1_c = '0;
      s2_c = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         s1_c[i] = float1[i*FLOAT_WIDTH + (FLOAT_WIDTH-1)];
         s2_c[i] = float2[i*FLOAT_WIDTH + (FLOAT_WIDTH-1)];
      end
   end

   // New sign per lane; undefined opcodes keep float1's sign.
   always_comb begin
      sgn_c = s1_c;
      inv_c = 1'b0;
      case (sgnj_type)
         RM_J:    sgn_c = s2_c;
         RM_JN:   sgn_c = ~s2_c;
         RM_JX:   sgn_c = s1_c ^ s2_c;
         default: inv_c = 1'b1;
      endcase
   end

   // Only the sign bit is replaced; exponent/fraction (incl. NaN payloads) pass through.
   always_comb begin
      res_c = float1;
      for (int unsigned i = 0; i < LANES; i++) begin
         res_c[i*FLOAT_WIDTH + (FLOAT_WIDTH-1)] = lane_en[i] ? sgn_c[i] : s1_c[i];
      end
   end

   assign advance_c = out_ready | ~vld_q[LAST];
   assign in_ready  = advance_c;

   // Whole pipeline shifts together on advance, bubbles included.
   always_comb begin
      vld_d  = vld_q;
      inv_d  = inv_q;
      data_d = data_q;
      if (advance_c) begin
         vld_d[0]  = in_valid;
         inv_d[0]  = in_valid & inv_c;
         data_d[0] = res_c;
         for (int unsigned s = 1; s < PIPE_DEPTH; s++) begin
            vld_d[s]  = vld_q[s-1];
            inv_d[s]  = inv_q[s-1];
            data_d[s] = data_q[s-1];
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         vld_q <= '0;
         inv_q <= '0;
         for (int unsigned s = 0; s < PIPE_DEPTH; s++) begin
            data_q[s] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         inv_q <= inv_d;
         for (int unsigned s = 0; s < PIPE_DEPTH; s++) begin
            data_q[s] <= data_d[s];
         end
      end
   end

   assign out_valid  = vld_q[LAST];
   assign out        = data_q[LAST];
   assign invalid_op = vld_q[LAST] & inv_q[LAST];

endmodule
